apb_stdout_fifo: RTL and testbench

Parametrised successor to the simulation-only core stdout sink: an APB slave that collects per-core character writes from all clusters into one hardware FIFO and drains them as tagged entries over a valid/ready stream toward the host-side debug path. It adds a status and drop-counter register window, an interrupt for pending lines, and a compile-time choice between dropping and stalling on overflow. It sits on the SoC peripheral APB bus in place of the stdout sink and is usable identically in simulation and synthesis.

---
 rtl/apb_stdout_fifo.sv | 195 +++++++++++++++++++
 tb/tb_apb_stdout_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_stdout_fifo.sv
// APB stdout collector: per-core char writes -> one FWFT FIFO -> tagged valid/ready stream; APB_STDOUT_BLOCKING_EN selects stall vs drop.
// Latency: entry written on the completing APB edge, visible on out_valid_o/STATUS/irq_o the next cycle; register reads are combinational.
// Backpressure: full FIFO drops and counts (default) or holds pready low (APB_STDOUT_BLOCKING_EN); a same-cycle pop always frees a slot.

module apb_stdout_sfifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dat,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wptr] <= i_dat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  // Zero when empty so the stream output has a defined value out of reset.
  assign o_dat   = o_empty ? '0 : r_mem[r_rptr];
endmodule

module apb_stdout_fifo #(
  parameter int N_CORES    = 8,
  parameter int N_CLUSTERS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 128,
  parameter int IRQ_THRESH = 96
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  apb_psel_i,
  input  logic                  apb_penable_i,
  input  logic                  apb_pwrite_i,
  input  logic [ADDR_WIDTH-1:0] apb_paddr_i,
  input  logic [DATA_WIDTH-1:0] apb_pwdata_i,
  output logic [DATA_WIDTH-1:0] apb_prdata_o,
  output logic                  apb_pready_o,
  output logic                  apb_pslverr_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [23:0]           out_data_o,
  output logic                  irq_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [4:0] NCL = 5'(N_CLUSTERS);
  localparam logic [4:0] NCO = 5'(N_CORES);

  typedef struct packed {
    logic [7:0] cl;
    logic [7:0] core;
    logic [7:0] ch;
  } entry_t;

  logic          w_access, w_chan, w_idx_ok, w_push_req;
  logic          w_push, w_pop, w_drop, w_drop_clr;
  logic          w_empty, w_full;
  logic [3:0]    w_cl, w_core;
  logic [1:0]    w_off;
  logic [CW-1:0] w_count, w_count_nxt, w_nl_nxt;
  entry_t        w_push_dat, w_head;
  logic [31:0]   w_status;
  logic          w_unused;

  logic [CW-1:0] r_nl;
  logic [31:0]   r_drop;
  logic          r_irq;

  assign w_access   = apb_psel_i && apb_penable_i;
  assign w_chan     = !apb_paddr_i[11];
  assign w_cl       = apb_paddr_i[10:7];
  assign w_core     = apb_paddr_i[6:3];
  assign w_off      = apb_paddr_i[3:2];
  assign w_idx_ok   = ({1'b0, w_cl} < NCL) && ({1'b0, w_core} < NCO);
  assign w_push_req = w_access && apb_pwrite_i && w_chan && w_idx_ok;
  assign w_pop      = out_valid_o && out_ready_i;

`ifdef APB_STDOUT_BLOCKING_EN
  assign apb_pready_o = !(w_push_req && w_full && !w_pop);
  assign w_drop       = 1'b0;
`else
  assign apb_pready_o = 1'b1;
  assign w_drop       = w_push_req && w_full && !w_pop;
`endif

  assign w_push     = w_push_req && apb_pready_o && (!w_full || w_pop);
  assign w_drop_clr = w_access && apb_pwrite_i && !w_chan && (w_off == 2'd1);
  assign w_push_dat = '{cl: {4'b0, w_cl}, core: {4'b0, w_core}, ch: apb_pwdata_i[7:0]};

  apb_stdout_sfifo #(.WIDTH(24), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_dat   (w_push_dat),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign out_valid_o = !w_empty;
  assign out_data_o  = w_head;
  assign irq_o       = r_irq;

  always_comb begin
    w_count_nxt = w_count;
    if (w_push && !w_pop) w_count_nxt = w_count + CW'(1);
    if (!w_push && w_pop) w_count_nxt = w_count - CW'(1);
  end

  // Newline count tracks entries currently held, so push and pop of 0x0A cancel.
  always_comb begin
    w_nl_nxt = r_nl;
    case ({w_push && (w_push_dat.ch == 8'h0A), w_pop && (w_head.ch == 8'h0A)})
      2'b10:   w_nl_nxt = r_nl + CW'(1);
      2'b01:   w_nl_nxt = r_nl - CW'(1);
      default: w_nl_nxt = r_nl;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_nl   <= '0;
      r_drop <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_nl  <= w_nl_nxt;
      r_irq <= (w_count_nxt >= CW'(IRQ_THRESH)) || (w_nl_nxt != '0);
      if (w_drop_clr)
        r_drop <= '0;
      else if (w_drop && (r_drop != 32'hFFFF_FFFF))
        r_drop <= r_drop + 32'd1;
    end
  end

  always_comb begin
    w_status       = '0;
    w_status[0]    = w_empty;
    w_status[1]    = w_full;
    w_status[2]    = r_irq;
    w_status[23:8] = 16'(w_count);
  end

  always_comb begin
    apb_prdata_o  = '0;
    apb_pslverr_o = 1'b0;
    if (w_access) begin
      if (w_chan) begin
        apb_pslverr_o = apb_pwrite_i && !w_idx_ok;
      end else begin
        case (w_off)
          2'd0:    apb_prdata_o = DATA_WIDTH'(w_status);
          2'd1:    apb_prdata_o = DATA_WIDTH'(r_drop);
          2'd2:    apb_prdata_o = DATA_WIDTH'(r_nl);
          default: apb_pslverr_o = 1'b1;
        endcase
      end
    end
  end

  assign w_unused = &{1'b0, apb_pwdata_i[DATA_WIDTH-1:8], apb_paddr_i[ADDR_WIDTH-1:12], apb_paddr_i[1:0]};
endmodule

// File: tb/tb_apb_stdout_fifo.sv
// Directed + seeded-random bench for apb_stdout_fifo with a 4-deep FIFO; honours APB_STDOUT_BLOCKING_EN.
module tb_apb_stdout_fifo;
  localparam int FD  = 4;
  localparam int TH  = 3;
  localparam int NCL = 4;
  localparam int NCO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        out_valid, out_ready, irq;
  logic [23:0] out_data;

  int n_chk  = 0;
  int n_fail = 0;
  int drops  = 0;
  logic [23:0] q[$];

  always #5 clk = ~clk;

  apb_stdout_fifo #(
    .N_CORES(NCO), .N_CLUSTERS(NCL), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .FIFO_DEPTH(FD), .IRQ_THRESH(TH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .apb_psel_i(psel), .apb_penable_i(penable), .apb_pwrite_i(pwrite),
    .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_prdata_o(prdata),
    .apb_pready_o(pready), .apb_pslverr_o(pslverr),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic pop_acc,
                     output logic [31:0] rd, output logic err, output int stall);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; out_ready = 1'b0;
    @(negedge clk);
    penable = 1'b1; out_ready = pop_acc;
    #1;
    stall = 0;
    while (!pready && stall < 20) begin
      @(negedge clk); #1;
      stall++;
    end
    rd = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; out_ready = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] addr, output logic [31:0] rd, output logic err);
    int st;
    apb(1'b0, addr, 32'h0, 1'b0, rd, err, st);
  endtask

  task automatic do_write(input int cl, input int core, input logic [7:0] ch, input logic pop_acc);
    logic [31:0] rd; logic err; int st; logic ok; logic popd;
    ok   = (cl < NCL) && (core < NCO);
    popd = pop_acc && (q.size() > 0);
    apb(1'b1, 32'((cl << 7) | (core << 3)), {24'hA5C3E1, ch}, pop_acc, rd, err, st);
    chk("wr_slverr", {31'b0, err}, {31'b0, !ok});
    chk("wr_stall", st, 0);
    if (popd) void'(q.pop_front());
    if (ok) begin
      if (q.size() < FD) q.push_back({cl[7:0], core[7:0], ch});
      else drops++;
    end
  endtask

  task automatic pop_one();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic check_state();
    int sz; int nl; logic ie; logic [31:0] s; logic [31:0] rd; logic err;
    sz = q.size();
    nl = 0;
    for (int i = 0; i < sz; i++) if (q[i][7:0] == 8'h0A) nl++;
    ie = (sz >= TH) || (nl != 0);
    s = '0;
    s[0] = (sz == 0); s[1] = (sz == FD); s[2] = ie; s[23:8] = 16'(sz);
    chk("out_valid", {31'b0, out_valid}, {31'b0, sz > 0});
    chk("out_data", {8'b0, out_data}, (sz > 0) ? {8'b0, q[0]} : 32'h0);
    chk("irq", {31'b0, irq}, {31'b0, ie});
    rd_reg(32'h800, rd, err);
    chk("status", rd, s);
    rd_reg(32'h808, rd, err);
    chk("nl_cnt", rd, 32'(nl));
    rd_reg(32'h804, rd, err);
    chk("drop_cnt", rd, 32'(drops));
  endtask

  initial begin
    logic [31:0] rd; logic err; int st; int cl; int core; logic [7:0] ch; logic pa;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_data", {8'b0, out_data}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    check_state();

    // First push: cluster 1, core 2, 'A'
    do_write(1, 2, 8'h41, 1'b0);
    chk("tp1_valid", {31'b0, out_valid}, 32'h1);
    chk("tp1_data", {8'b0, out_data}, 32'h0001_0241);
    chk("tp1_irq", {31'b0, irq}, 32'h0);
    rd_reg(32'h800, rd, err);
    chk("tp1_status", rd, 32'h0000_0100);
    pop_one();
    check_state();

    // Newline raises irq until popped
    do_write(0, 0, 8'h0A, 1'b0);
    chk("nl_irq_hi", {31'b0, irq}, 32'h1);
    rd_reg(32'h808, rd, err);
    chk("nl_cnt_1", rd, 32'h1);
    pop_one();
    chk("nl_irq_lo", {31'b0, irq}, 32'h0);
    rd_reg(32'h808, rd, err);
    chk("nl_cnt_0", rd, 32'h0);

    // Out-of-range indices and odd register accesses
    do_write(NCL, 0, 8'h55, 1'b0);
    check_state();
    do_write(0, NCO, 8'h56, 1'b0);
    check_state();
    rd_reg(32'h090, rd, err);
    chk("chan_rd_data", rd, 32'h0);
    chk("chan_rd_err", {31'b0, err}, 32'h0);
    rd_reg(32'h80C, rd, err);
    chk("bad_off_data", rd, 32'h0);
    chk("bad_off_err", {31'b0, err}, 32'h1);
    apb(1'b1, 32'h80C, 32'h1234, 1'b0, rd, err, st);
    chk("bad_off_wr_err", {31'b0, err}, 32'h1);
    apb(1'b1, 32'h800, 32'hFFFF_FFFF, 1'b0, rd, err, st);
    chk("ro_wr_err", {31'b0, err}, 32'h0);
    check_state();

    // Fill to full
    for (int k = 0; k < FD; k++) begin
      do_write(k % NCL, k, 8'(8'h30 + k), 1'b0);
      check_state();
    end
    rd_reg(32'h800, rd, err);
    chk("full_status", rd, 32'h0000_0406);

`ifdef APB_STDOUT_BLOCKING_EN
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h188; pwdata = 32'h62; out_ready = 1'b0;
    @(negedge clk);
    penable = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("blk_pready_lo", {31'b0, pready}, 32'h0);
      @(negedge clk); #1;
    end
    out_ready = 1'b1; #1;
    chk("blk_pready_hi", {31'b0, pready}, 32'h1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; out_ready = 1'b0;
    void'(q.pop_front());
    q.push_back(24'h03_01_62);
    check_state();
`else
    for (int k = 0; k < 3; k++) do_write(3, 7, 8'h21, 1'b0);
    check_state();
    rd_reg(32'h804, rd, err);
    chk("drop_3", rd, 32'h3);
    apb(1'b1, 32'h804, 32'h0, 1'b0, rd, err, st);
    chk("drop_clr_err", {31'b0, err}, 32'h0);
    drops = 0;
    rd_reg(32'h804, rd, err);
    chk("drop_clr", rd, 32'h0);
    do_write(2, 3, 8'h77, 1'b1);
    check_state();
`endif

    for (int i = 0; i < FD + 2 && q.size() > 0; i++) begin
      pop_one();
      check_state();
    end

    // Random mix; the model decides pops/pushes/drops
    for (int it = 0; it < 40; it++) begin
      cl   = $urandom_range(0, 5);
      core = $urandom_range(0, 9);
      ch   = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(32, 126));
      pa   = 1'($urandom_range(0, 1));
`ifdef APB_STDOUT_BLOCKING_EN
      if (q.size() == FD) pa = 1'b1;
`endif
      do_write(cl, core, ch, pa);
      check_state();
      if ($urandom_range(0, 3) == 0) begin
        pop_one();
        check_state();
      end
    end

    // Reset in the middle of traffic
    pop_one();
    do_write(1, 1, 8'h0A, 1'b0);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_data", {8'b0, out_data}, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    drops = 0;
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
